// File: rtl/csr_access_unit.sv
// csr_access_unit: Zicsr read-modify-write sequencer with trap/mret redirect.
// Define CSR_ACCESS_TIMEOUT_EN to add a 4-bit watchdog on WRITE/TRAP_WAIT.
module csr_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [63:0] req_src,
  input  logic        req_src_zero,
  output logic        csr_ren,
  output logic [11:0] csr_raddr,
  input  logic [63:0] csr_rdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  input  logic        csr_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic [63:0] mtvec_in,
  input  logic [63:0] mepc_in,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        flush
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, TRAP_WAIT, REDIRECT} state_t;
  state_t state, state_n;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [63:0] src, old, new_val;
  logic        src_zero, is_mret, skip, timeout, waiting;
  assign new_val = op == 2'd1 ? (old | src) : op == 2'd2 ? (old & ~src) : src;
  assign skip    = (op == 2'd1 || op == 2'd2) && src_zero;
  assign waiting = state == WRITE || state == TRAP_WAIT;
`ifdef CSR_ACCESS_TIMEOUT_EN
  logic [3:0] cnt;
  logic       err;
  // Exit on the cycle the count would reach 15, giving exactly 15 stalled cycles.
  assign timeout = waiting && !csr_ready && cnt == 4'd14;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= 4'd0;
      err <= 1'b0;
    end else begin
      if ((state_n == WRITE || state_n == TRAP_WAIT) && state_n != state) cnt <= 4'd0;
      else if (waiting && !csr_ready) cnt <= cnt + 4'd1;
      if (state == WRITE && timeout) err <= 1'b1;
      else if (state == RESP && (resp_ready || flush)) err <= 1'b0;
    end
  assign resp_err = resp_valid && err;
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (trap_req || mret_req) ? TRAP_WAIT : req_valid ? READ : IDLE;
      READ:      state_n = flush ? IDLE : skip ? RESP : WRITE;
      WRITE:     state_n = (csr_ready || timeout) ? RESP : WRITE;
      RESP:      state_n = (flush || resp_ready) ? IDLE : RESP;
      TRAP_WAIT: state_n = (csr_ready || timeout) ? REDIRECT : TRAP_WAIT;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      op       <= 2'd0;
      addr     <= 12'd0;
      src      <= 64'd0;
      src_zero <= 1'b0;
      old      <= 64'd0;
      is_mret  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && (trap_req || mret_req)) is_mret <= !trap_req;
      else if (state == IDLE && req_valid) begin
        op       <= req_op;
        addr     <= req_addr;
        src      <= req_src;
        src_zero <= req_src_zero;
      end
      if (state == READ) old <= csr_rdata;
    end
  assign req_ready      = !reset && state == IDLE && !trap_req && !mret_req;
  assign csr_ren        = !reset && state == READ;
  assign csr_raddr      = csr_ren ? addr : 12'd0;
  assign csr_wen        = !reset && state == WRITE;
  assign csr_waddr      = csr_wen ? addr : 12'd0;
  assign csr_wdata      = csr_wen ? new_val : 64'd0;
  assign resp_valid     = !reset && state == RESP;
  assign resp_rdata     = resp_valid ? old : 64'd0;
  assign redirect_valid = !reset && state == REDIRECT;
  assign redirect_pc    = !redirect_valid ? 64'd0 : is_mret ? mepc_in : (mtvec_in & ~64'd3);
endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have clk, input, 1: clock; all state changes on rising edge.
REQ-002 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have req_valid in 1, req_ready out 1, req_op in 2 (0=RW, 1=RS, 2=RC, 3=reserved, treated as RW), req_addr in 12, req_src in 64 (rs1 value or zero-extended zimm), req_src_zero in 1 (rs1==x0 / zimm==0).
REQ-004 SHALL have csr_ren out 1, csr_raddr out 12, csr_rdata in 64, csr_wen out 1, csr_waddr out 12, csr_wdata out 64, csr_ready in 1 (CSR file commit-done flag).
REQ-005 SHALL have resp_valid out 1, resp_ready in 1, resp_rdata out 64 (old CSR value), resp_err out 1.
REQ-006 SHALL have trap_req in 1, mret_req in 1, mtvec_in in 64, mepc_in in 64, redirect_valid out 1, redirect_pc out 64, flush in 1.

Function
REQ-007 SHALL implement states IDLE, READ, WRITE, RESP, TRAP_WAIT, REDIRECT.
REQ-008 SHALL drive req_ready = (state==IDLE) && !trap_req && !mret_req; a request is accepted on req_valid && req_ready, latching op, addr, src, src_zero; next state READ.
REQ-009 IDLE priority SHALL be trap_req > mret_req > req_valid; trap/mret latch kind (EXC/MRET) and go to TRAP_WAIT.
REQ-010 READ (exactly 1 cycle): csr_ren=1, csr_raddr=latched addr; csr_rdata captured into old at cycle end.
REQ-011 New value SHALL be RW: src; RS: old | src; RC: old & ~src; all 64-bit, no truncation.
REQ-012 After READ: RS/RC with src_zero SHALL skip the write and go to RESP; otherwise go to WRITE.
REQ-013 WRITE: csr_wen=1, csr_waddr=addr, csr_wdata=new value, held constant every cycle until csr_ready==1 is sampled, then RESP.
REQ-014 RESP: resp_valid=1, resp_rdata=old, held stable until resp_ready; on handshake go to IDLE.
REQ-015 TRAP_WAIT: wait until csr_ready==1, then REDIRECT.
REQ-016 REDIRECT (exactly 1 cycle): redirect_valid=1; redirect_pc = {mtvec_in[63:2],2'b00} for EXC, mepc_in for MRET; sampled in REDIRECT cycle; then IDLE.
REQ-017 flush in READ or RESP SHALL return to IDLE next cycle with no write issued/response dropped; flush SHALL be ignored in WRITE, TRAP_WAIT, REDIRECT, IDLE.
REQ-018 All outputs not named active in the current state SHALL be 0; csr_raddr/csr_waddr/csr_wdata/resp_rdata/redirect_pc 0 when inactive.
REQ-019 Minimum latency: accept -> resp_valid = 2 cycles when write skipped; 3 cycles with write and csr_ready high on first WRITE cycle.
REQ-020 trap_req/mret_req arriving outside IDLE SHALL be ignored (pipeline guarantees hold until accepted).

Reset
REQ-021 While reset=1: state=IDLE, all outputs 0 (req_ready included), latched fields and old cleared; reset mid-operation aborts without further csr_wen.
REQ-022 First cycle after reset deassertion SHALL present req_ready=1 if trap_req=mret_req=0.

Configuration
REQ-023 Macro CSR_ACCESS_TIMEOUT_EN SHALL add a 4-bit watchdog counter cleared on entry to WRITE/TRAP_WAIT and incremented each cycle there without csr_ready.
REQ-024 With CSR_ACCESS_TIMEOUT_EN: counter reaching 15 SHALL force exit: WRITE -> RESP with resp_err=1; TRAP_WAIT -> REDIRECT with resp_err unchanged; resp_err cleared on RESP handshake.
REQ-025 Without CSR_ACCESS_TIMEOUT_EN: no counter, resp_err tied 0, WRITE/TRAP_WAIT wait indefinitely.

Verification
REQ-026 RS addr=0x300, src=0x8, csr_rdata=0x1800, csr_ready high 1 cycle after wen -> csr_wdata=0x1808, resp_rdata=0x1800, resp_err=0.
REQ-027 RC addr=0x344, src_zero=1, csr_rdata=0xFF -> no csr_wen ever, resp_valid 2 cycles after accept with resp_rdata=0xFF.
REQ-028 RW addr=0x305, src=0x80000101, resp_ready low 3 cycles -> csr_wdata=0x80000101, resp_valid/resp_rdata stable 4 cycles, req_ready=0 throughout.
REQ-029 trap_req and req_valid same IDLE cycle, mtvec_in=0x80000103 -> req not accepted, redirect_valid one cycle with redirect_pc=0x80000100 after csr_ready.
REQ-030 mret_req, mepc_in=0x80001234 -> redirect_pc=0x80001234; reset asserted during WRITE -> csr_wen 0 next cycle, req_ready 1 after release.
REQ-031 CSR_ACCESS_TIMEOUT_EN defined, RW with csr_ready stuck 0 -> resp_valid with resp_err=1 after 15 WRITE cycles; undefined build -> still in WRITE at cycle 100.
